// File: rtl/mem_access_ctrl_if.sv
// Bundle of EX/MEM-side, data-memory-side and hazard-side signals of the MEM-stage sequencer.
// Latency: none, signals only.
// Backpressure: MemReady from memory throttles the access; StallM is returned to the pipeline.
//
// master: the sequencer (drives MemReq/MemWe/MemAddr/MemWData, StallM, ReadDataM, MisalignM, MemErr).
// slave : surrounding pipeline plus data memory (drives the EX/MEM fields, MemReady, MemRData).

interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  // EX/MEM register fields
  logic                  ValidM;
  logic                  FlushM;
  logic                  MemWriteM;
  logic [1:0]            ResultSrcM;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  // data memory port
  logic                  MemReq;
  logic                  MemWe;
  logic [DATA_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemWData;
  logic                  MemReady;
  logic [DATA_WIDTH-1:0] MemRData;
  // hazard unit / MEM/WB
  logic                  StallM;
  logic [DATA_WIDTH-1:0] ReadDataM;
  logic                  MisalignM;
  logic                  MemErr;

  modport master (
    input  ValidM, FlushM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
    input  MemReady, MemRData,
    output MemReq, MemWe, MemAddr, MemWData,
    output StallM, ReadDataM, MisalignM, MemErr
  );

  modport slave (
    output ValidM, FlushM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
    output MemReady, MemRData,
    input  MemReq, MemWe, MemAddr, MemWData,
    input  StallM, ReadDataM, MisalignM, MemErr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues a word load/store to a variable-latency data memory and stalls the pipeline.
// Latency: 2 cycles minimum (request cycle with MemReady, then DONE); aborts after TIMEOUT unanswered cycles.
// Backpressure: holds MemReq/addr/data/we stable until MemReady; StallM freezes upstream stages meanwhile.
//
// Ports: clk, rst_n (async active-low); bus (master modport) carries the EX/MEM fields,
// the memory req/ready port, StallM to the hazard unit and ReadDataM/MisalignM/MemErr to MEM/WB.

module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16   // must be >= 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_ctrl_if.master   bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;
  logic                  err_q, err_d;

  logic access;
  logic aligned;
  logic is_load;
  logic req;
  logic stall;

  always_comb begin
    access  = bus.ValidM & ~bus.FlushM & (bus.MemWriteM | (bus.ResultSrcM == 2'b01));
    aligned = (bus.ALUResultM[1:0] == 2'b00);
    // A store wins if both flags are set, so ReadDataM is only loaded by true loads.
    is_load = ~bus.MemWriteM & (bus.ResultSrcM == 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  // The counter holds the number of unanswered request cycles already seen,
  // the IDLE request cycle included, so the abort lands after TIMEOUT cycles of StallM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    err_d      = err_q;
    req        = 1'b0;
    stall      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (access) begin
          stall = 1'b1;
          if (aligned) begin
            req = 1'b1;
            if (bus.MemReady) begin
              state_d = ST_DONE;
              if (is_load) begin
                rdata_d = bus.MemRData;
              end
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CW'(1);
            end
          end else begin
            // Misaligned: no memory request, just a one-cycle stall and a flag.
            state_d    = ST_DONE;
            misalign_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        // FlushM is ignored here: an issued request always runs to completion.
        stall = 1'b1;
        req   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (bus.MemReady) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (is_load) begin
            rdata_d = bus.MemRData;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gating with rst_n drops the request and stall immediately while reset is held,
  // even though IDLE otherwise reflects AccessM combinationally.
  assign bus.MemReq    = rst_n & req;
  assign bus.StallM    = rst_n & stall;
  assign bus.MemWe     = bus.MemReq & bus.MemWriteM;
  assign bus.MemAddr   = bus.ALUResultM;
  assign bus.MemWData  = bus.WriteDataM;
  assign bus.ReadDataM = rdata_q;
  assign bus.MisalignM = misalign_q;
  assign bus.MemErr    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: hand-computed expectations per scenario.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
// Each task checks its own results inline.

module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_access_ctrl_if #(.DATA_WIDTH(32)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ValidM     = 1'b0;
    bus.FlushM     = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ResultSrcM = 2'b00;
    bus.ALUResultM = 32'h0;
    bus.WriteDataM = 32'h0;
    bus.MemReady   = 1'b0;
    bus.MemRData   = 32'h0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic rdy, input logic [31:0] rdata);
    bus.ValidM     = 1'b1;
    bus.FlushM     = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ResultSrcM = 2'b01;
    bus.ALUResultM = addr;
    bus.WriteDataM = 32'h0;
    bus.MemReady   = rdy;
    bus.MemRData   = rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_load(32'h100, 1'b0, 32'h0);
    #12;
    checks++;
    if ({bus.MemReq, bus.StallM, bus.MisalignM, bus.MemErr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got req/stall/mis/err=%b want 0000",
               {bus.MemReq, bus.StallM, bus.MisalignM, bus.MemErr});
    end
    checks++;
    if (bus.ReadDataM !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h want 00000000", bus.ReadDataM);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_fast();
    drive_load(32'h100, 1'b1, 32'h12345678);
    #1;
    checks++;
    if ({bus.MemReq, bus.MemWe, bus.StallM, bus.MemAddr} !== {3'b101, 32'h100}) begin
      failures++;
      $display("FAIL load_fast_req: got req/we/stall=%b addr=%h want 101 addr=00000100",
               {bus.MemReq, bus.MemWe, bus.StallM}, bus.MemAddr);
    end
    tick();
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM, bus.MemErr, bus.MisalignM} !== 4'b0000) begin
      failures++;
      $display("FAIL load_fast_done: got req/stall/err/mis=%b want 0000",
               {bus.MemReq, bus.StallM, bus.MemErr, bus.MisalignM});
    end
    checks++;
    if (bus.ReadDataM !== 32'h12345678) begin
      failures++;
      $display("FAIL load_fast_rdata: got %h want 12345678", bus.ReadDataM);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_store_wait();
    bus.ValidM     = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.ResultSrcM = 2'b00;
    bus.ALUResultM = 32'h204;
    bus.WriteDataM = 32'hCAFEF00D;
    bus.MemRData   = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      bus.MemReady = (i == 3);
      #1;
      checks++;
      if ({bus.MemReq, bus.MemWe, bus.StallM, bus.MemAddr, bus.MemWData} !==
          {3'b111, 32'h204, 32'hCAFEF00D}) begin
        failures++;
        $display("FAIL store_wait_c%0d: got req/we/stall=%b addr=%h wdata=%h want 111 00000204 cafef00d",
                 i, {bus.MemReq, bus.MemWe, bus.StallM}, bus.MemAddr, bus.MemWData);
      end
      tick();
    end
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM, bus.MemErr} !== 3'b000 || bus.ReadDataM !== 32'h12345678) begin
      failures++;
      $display("FAIL store_done: got req/stall/err=%b rdata=%h want 000 12345678",
               {bus.MemReq, bus.StallM, bus.MemErr}, bus.ReadDataM);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_misalign();
    drive_load(32'h102, 1'b0, 32'h0);
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM} !== 2'b01) begin
      failures++;
      $display("FAIL misalign_req: got req/stall=%b want 01", {bus.MemReq, bus.StallM});
    end
    tick();
    #1;
    checks++;
    if ({bus.MisalignM, bus.MemReq, bus.StallM} !== 3'b100) begin
      failures++;
      $display("FAIL misalign_done: got mis/req/stall=%b want 100",
               {bus.MisalignM, bus.MemReq, bus.StallM});
    end
    idle_inputs();
    tick();
    #1;
    checks++;
    if ({bus.MisalignM, bus.StallM} !== 2'b00 || bus.ReadDataM !== 32'h12345678) begin
      failures++;
      $display("FAIL misalign_after: got mis/stall=%b rdata=%h want 00 12345678",
               {bus.MisalignM, bus.StallM}, bus.ReadDataM);
    end
    tick();
  endtask

  task automatic test_flush();
    // Flushed load in IDLE: nothing happens.
    drive_load(32'h400, 1'b1, 32'h77777777);
    bus.FlushM = 1'b1;
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM} !== 2'b00) begin
      failures++;
      $display("FAIL flush_idle: got req/stall=%b want 00", {bus.MemReq, bus.StallM});
    end
    // Valid but neither load nor store.
    bus.FlushM     = 1'b0;
    bus.ResultSrcM = 2'b00;
    tick();
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM} !== 2'b00 || bus.ReadDataM !== 32'h12345678) begin
      failures++;
      $display("FAIL non_access: got req/stall=%b rdata=%h want 00 12345678",
               {bus.MemReq, bus.StallM}, bus.ReadDataM);
    end
    tick();
    // Flush raised after the request is issued: the access still completes.
    drive_load(32'h400, 1'b0, 32'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      bus.FlushM   = (i != 0);
      bus.MemReady = (i == 2);
      #1;
      checks++;
      if ({bus.MemReq, bus.StallM} !== 2'b11) begin
        failures++;
        $display("FAIL flush_wait_c%0d: got req/stall=%b want 11", i, {bus.MemReq, bus.StallM});
      end
      tick();
    end
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if (bus.StallM !== 1'b0 || bus.ReadDataM !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL flush_wait_done: got stall=%b rdata=%h want 0 0badf00d", bus.StallM, bus.ReadDataM);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_near_timeout();
    drive_load(32'h304, 1'b0, 32'hA5A55A5A);
    for (int i = 0; i < 16; i++) begin
      bus.MemReady = (i == 15);
      #1;
      checks++;
      if ({bus.MemReq, bus.StallM} !== 2'b11) begin
        failures++;
        $display("FAIL near_timeout_c%0d: got req/stall=%b want 11", i, {bus.MemReq, bus.StallM});
      end
      tick();
    end
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if ({bus.StallM, bus.MemErr} !== 2'b00 || bus.ReadDataM !== 32'hA5A55A5A) begin
      failures++;
      $display("FAIL near_timeout_done: got stall/err=%b rdata=%h want 00 a5a55a5a",
               {bus.StallM, bus.MemErr}, bus.ReadDataM);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int req_drop;
    n        = 0;
    req_drop = 0;
    drive_load(32'h300, 1'b0, 32'hDEADBEEF);
    #1;
    while (bus.StallM === 1'b1 && n < 40) begin
      if (bus.MemReq !== 1'b1) req_drop++;
      n++;
      tick();
      #1;
    end
    checks++;
    if (n != 16 || req_drop != 0) begin
      failures++;
      $display("FAIL timeout_len: got stall cycles=%0d req drops=%0d want 16 and 0", n, req_drop);
    end
    checks++;
    if (bus.MemErr !== 1'b1 || bus.ReadDataM !== 32'h0 || bus.MemReq !== 1'b0) begin
      failures++;
      $display("FAIL timeout_done: got err=%b rdata=%h req=%b want 1 00000000 0",
               bus.MemErr, bus.ReadDataM, bus.MemReq);
    end
    idle_inputs();
    tick();
    tick();
    #1;
    checks++;
    if (bus.MemErr !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: got err=%b want 1", bus.MemErr);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive_load(32'h500, 1'b0, 32'h0);
    tick();
    tick();
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM, bus.MemErr} !== 3'b111) begin
      failures++;
      $display("FAIL mid_wait_pre: got req/stall/err=%b want 111", {bus.MemReq, bus.StallM, bus.MemErr});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM, bus.MemErr} !== 3'b000) begin
      failures++;
      $display("FAIL mid_wait_rst: got req/stall/err=%b want 000", {bus.MemReq, bus.StallM, bus.MemErr});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive_load(32'h500, 1'b1, 32'h600DCAFE);
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM} !== 2'b11) begin
      failures++;
      $display("FAIL post_rst_req: got req/stall=%b want 11", {bus.MemReq, bus.StallM});
    end
    tick();
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if ({bus.StallM, bus.MemErr} !== 2'b00 || bus.ReadDataM !== 32'h600DCAFE) begin
      failures++;
      $display("FAIL post_rst_done: got stall/err=%b rdata=%h want 00 600dcafe",
               {bus.StallM, bus.MemErr}, bus.ReadDataM);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    drive_load(32'h10, 1'b1, 32'h11111111);
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_first_req: got req/stall=%b want 11", {bus.MemReq, bus.StallM});
    end
    tick();
    // DONE: EX/MEM still shows the first load, which must not be re-issued.
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM} !== 2'b00 || bus.ReadDataM !== 32'h11111111) begin
      failures++;
      $display("FAIL b2b_gap: got req/stall=%b rdata=%h want 00 11111111",
               {bus.MemReq, bus.StallM}, bus.ReadDataM);
    end
    tick();
    drive_load(32'h14, 1'b1, 32'h22222222);
    #1;
    checks++;
    if ({bus.MemReq, bus.StallM} !== 2'b11 || bus.MemAddr !== 32'h14) begin
      failures++;
      $display("FAIL b2b_second_req: got req/stall=%b addr=%h want 11 00000014",
               {bus.MemReq, bus.StallM}, bus.MemAddr);
    end
    tick();
    bus.MemReady = 1'b0;
    #1;
    checks++;
    if (bus.ReadDataM !== 32'h22222222 || bus.StallM !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_done: got rdata=%h stall=%b want 22222222 0", bus.ReadDataM, bus.StallM);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_load_fast();
    test_store_wait();
    test_misalign();
    test_flush();
    test_near_timeout();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
